bcd_down_timer: RTL

Two-digit BCD down-counter/timer: the count-down counterpart to the team's 0-to-9 up counter. Loads a BCD preset (00–99), then decrements it one step per enabled tick toward 00 and flags completion with a one-cycle `done` pulse. Used as a countdown source for display and timing logic. It shares the counter family's `clk`/`rst`/`en` style, so the two can be cascaded and driven from the same stimulus.

---
 rtl/bcd_down_timer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: two-digit BCD countdown timer with an enabled-cycle prescaler.
// Loads a BCD preset, decrements once every TICK_DIV enabled cycles while
// running, and pulses done for one cycle when the count reaches 00.
// Optional feature macro: BCD_DOWN_TIMER_AUTO_RELOAD_EN. When defined, the
// timer stays running at 00 and the next tick reloads the last valid preset.
module bcd_down_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic       load_err
);

  // Prescaler terminal value; the prescaler only advances while running.
  localparam logic [15:0] PS_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [15:0] presc_q, presc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  // Last valid preset, restored by the tick that follows reaching 00.
  logic [3:0]  rl_tens_q, rl_tens_d;
  logic [3:0]  rl_ones_q, rl_ones_d;
`endif

  logic        load_ok;
  logic        count_nz;
  logic        advance;
  logic        tick;
  logic [3:0]  step_tens;
  logic [3:0]  step_ones;
  logic        step_zero;

  // Decode the request for this cycle; load and pause both block the tick.
  always_comb begin
    load_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
    count_nz = (tens_q != 4'd0) || (ones_q != 4'd0);
    advance  = !load && !pause && (state_q == S_RUN) && en;
    tick     = advance && (presc_q == PS_LAST);
  end

  // Value the digits take on a tick: BCD decrement with borrow, or reload at 00.
  always_comb begin
    step_tens = tens_q;
    step_ones = ones_q;
    if (ones_q != 4'd0) begin
      step_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      step_ones = 4'd9;
      step_tens = tens_q - 4'd1;
    end else begin
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
      step_tens = rl_tens_q;
      step_ones = rl_ones_q;
`else
      step_tens = 4'd0;
      step_ones = 4'd0;
`endif
    end
    step_zero = (step_tens == 4'd0) && (step_ones == 4'd0);
  end

  // Next-state logic: load > pause > start > tick.
  always_comb begin
    state_d = state_q;
    if (load) begin
      if (load_ok) begin
        state_d = S_IDLE;
      end
    end else if (pause) begin
      if (state_q == S_RUN) begin
        state_d = S_HOLD;
      end
    end else if (start && (state_q != S_RUN)) begin
      if ((state_q == S_HOLD) || count_nz) begin
        state_d = S_RUN;
      end
    end else if (tick) begin
`ifndef BCD_DOWN_TIMER_AUTO_RELOAD_EN
      if (step_zero) begin
        state_d = S_IDLE;
      end
`endif
    end
  end

  // Registered status outputs follow the state being entered.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = tick && step_zero;
  end

  // Datapath: digits, prescaler, reload register and sticky load error.
  always_comb begin
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    err_d   = err_q;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    rl_tens_d = rl_tens_q;
    rl_ones_d = rl_ones_q;
`endif
    if (load) begin
      if (load_ok) begin
        tens_d  = load_val[7:4];
        ones_d  = load_val[3:0];
        presc_d = 16'd0;
        err_d   = 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        rl_tens_d = load_val[7:4];
        rl_ones_d = load_val[3:0];
`endif
      end else begin
        err_d = 1'b1;
      end
    end else if (advance) begin
      if (tick) begin
        presc_d = 16'd0;
        tens_d  = step_tens;
        ones_d  = step_ones;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  // Reload register, cleared to 00 by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rl_tens_q <= 4'd0;
      rl_ones_q <= 4'd0;
    end else begin
      rl_tens_q <= rl_tens_d;
      rl_ones_q <= rl_ones_d;
    end
  end
`endif

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign load_err = err_q;

endmodule
